// File: rtl/demod_scan_pkg.sv
// demod_scan_pkg
// Shared definitions for the demodulator channel-scan controller:
//   - scan FSM state encoding (legacy-compatible logic [2:0] constants)
//   - default SETTLE / AVG_LOG2 values
//   - acc_width(): width of the magnitude accumulator
package demod_scan_pkg;

    localparam int PHASE_WIDTH_DEF  = 32;
    localparam int OUTPUT_WIDTH_DEF = 24;
    localparam int SETTLE_DEF       = 64;
    localparam int AVG_LOG2_DEF     = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TUNE    = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_DECIDE  = 3'd3;
    localparam logic [2:0] ST_LOCK    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Accumulator must hold 2^avg_log2 full-scale magnitudes without overflow.
    function automatic int acc_width(input int out_w, input int avg_log2);
        return out_w + avg_log2;
    endfunction

endpackage

// File: rtl/demod_scan_ctrl_if.sv
// demod_scan_ctrl_if
// Control/status and demodulator-side signals of the scan controller.
//   master : scan requester + demodulator model (drives start/stop/band/threshold/am_*)
//   slave  : demod_scan_ctrl (drives Fre_word/level/busy/locked/done)
interface demod_scan_ctrl_if #(
    parameter int PHASE_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 24
) ();
    logic                    start;
    logic                    stop;
    logic [PHASE_WIDTH-1:0]  f_start;
    logic [PHASE_WIDTH-1:0]  f_stop;
    logic [PHASE_WIDTH-1:0]  f_step;
    logic [OUTPUT_WIDTH-1:0] threshold;
    logic                    am_valid;
    logic [OUTPUT_WIDTH-1:0] am_in;
    logic [PHASE_WIDTH-1:0]  Fre_word;
    logic [OUTPUT_WIDTH-1:0] level;
    logic                    busy;
    logic                    locked;
    logic                    done;

    modport master (
        output start, stop, f_start, f_stop, f_step, threshold, am_valid, am_in,
        input  Fre_word, level, busy, locked, done
    );

    modport slave (
        input  start, stop, f_start, f_stop, f_step, threshold, am_valid, am_in,
        output Fre_word, level, busy, locked, done
    );
endinterface

// File: rtl/scan_level_avg.sv
// scan_level_avg
// Averages 2^AVG_LOG2 AM magnitude samples.
//   clk_in, RST  : clock, async active-high reset
//   clear        : drop any partial window (priority over am_valid)
//   am_valid     : sample strobe, am_in accumulated when high
//   window_done  : one-cycle pulse after the last sample of a window
//   average      : truncated mean of the last completed window (held)
module scan_level_avg
    import demod_scan_pkg::*;
#(
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int AVG_LOG2     = AVG_LOG2_DEF
) (
    input  logic                    clk_in,
    input  logic                    RST,
    input  logic                    clear,
    input  logic                    am_valid,
    input  logic [OUTPUT_WIDTH-1:0] am_in,
    output logic                    window_done,
    output logic [OUTPUT_WIDTH-1:0] average
);
    localparam int ACC_W = acc_width(OUTPUT_WIDTH, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]        acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    done_r;
    logic [OUTPUT_WIDTH-1:0] avg_r;
    logic [ACC_W-1:0]        sum_s;

    assign sum_s = acc_r + ACC_W'(am_in);

    // Window accumulator, sample counter and averaged result
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            acc_r  <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
            avg_r  <= '0;
        end else if (clear) begin
            acc_r  <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (am_valid) begin
            if (cnt_r == LAST_IDX) begin
                // The closing sample is folded in directly; acc restarts for the next window.
                avg_r  <= OUTPUT_WIDTH'(sum_s >> AVG_LOG2);
                acc_r  <= '0;
                cnt_r  <= '0;
                done_r <= 1'b1;
            end else begin
                acc_r  <= sum_s;
                cnt_r  <= cnt_r + CNT_W'(1);
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign window_done = done_r;
    assign average     = avg_r;

endmodule

// File: rtl/demod_scan_ctrl.sv
// demod_scan_ctrl
// Channel-scan controller for the IQ demodulator. Steps Fre_word from f_start
// to f_stop by f_step, discards SETTLE samples after each retune, averages
// 2^AVG_LOG2 magnitude samples and locks on the first channel whose average
// reaches threshold.
//   clk_in, RST : clock, async active-high reset
//   bus (slave) : start/stop pulses, band (f_start/f_stop/f_step, captured at
//                 start), live threshold, am_valid/am_in from the demodulator;
//                 Fre_word, level, busy, locked, done outputs (all registered)
// Optional feature macro: SCAN_AUTO_RESUME_EN -- keep measuring while locked
// and resume the scan after two consecutive below-threshold windows.
module demod_scan_ctrl
    import demod_scan_pkg::*;
#(
    parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF,
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int SETTLE       = SETTLE_DEF,
    parameter int AVG_LOG2     = AVG_LOG2_DEF
) (
    input  logic             clk_in,
    input  logic             RST,
    demod_scan_ctrl_if.slave bus
);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    logic [2:0]              state_r, state_nx_s;
    logic [PHASE_WIDTH-1:0]  fre_word_r, fre_word_nx_s;
    logic [PHASE_WIDTH-1:0]  f_stop_r, f_stop_nx_s;
    logic [PHASE_WIDTH-1:0]  f_step_r, f_step_nx_s;
    logic [OUTPUT_WIDTH-1:0] level_r, level_nx_s;
    logic [SET_W-1:0]        settle_cnt_r, settle_cnt_nx_s;
    logic                    busy_r, locked_r, done_r;
`ifdef SCAN_AUTO_RESUME_EN
    logic                    low_seen_r, low_seen_nx_s;
`endif

    logic                    start_ok_s;
    logic [PHASE_WIDTH:0]    next_sum_s;
    logic                    band_end_s;
    logic                    meas_s;
    logic                    avg_clear_s;
    logic                    avg_valid_s;
    logic                    window_done_s;
    logic [OUTPUT_WIDTH-1:0] avg_s;

    assign start_ok_s = bus.start && !bus.stop &&
                        ((state_r == ST_IDLE) || (state_r == ST_LOCK) || (state_r == ST_DONE));

    // One extra bit catches wrap-around past the top of the frequency range.
    assign next_sum_s = {1'b0, fre_word_r} + {1'b0, f_step_r};
    assign band_end_s = next_sum_s[PHASE_WIDTH] ||
                        (next_sum_s[PHASE_WIDTH-1:0] > f_stop_r) ||
                        (f_step_r == '0);

`ifdef SCAN_AUTO_RESUME_EN
    assign meas_s = (state_r == ST_MEASURE) || (state_r == ST_LOCK);
`else
    assign meas_s = (state_r == ST_MEASURE);
`endif
    // Averager is held empty whenever it is not measuring, so every window starts clean.
    assign avg_clear_s = !meas_s;
    assign avg_valid_s = bus.am_valid && meas_s;

    scan_level_avg #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .AVG_LOG2     (AVG_LOG2)
    ) u_avg (
        .clk_in      (clk_in),
        .RST         (RST),
        .clear       (avg_clear_s),
        .am_valid    (avg_valid_s),
        .am_in       (bus.am_in),
        .window_done (window_done_s),
        .average     (avg_s)
    );

    // Next-state and datapath decisions of the scan FSM
    always_comb begin
        state_nx_s      = state_r;
        fre_word_nx_s   = fre_word_r;
        f_stop_nx_s     = f_stop_r;
        f_step_nx_s     = f_step_r;
        level_nx_s      = level_r;
        settle_cnt_nx_s = settle_cnt_r;
`ifdef SCAN_AUTO_RESUME_EN
        low_seen_nx_s   = low_seen_r;
`endif
        if (bus.stop) begin
            state_nx_s      = ST_IDLE;
            settle_cnt_nx_s = '0;
        end else if (start_ok_s) begin
            state_nx_s      = ST_TUNE;
            fre_word_nx_s   = bus.f_start;
            f_stop_nx_s     = bus.f_stop;
            f_step_nx_s     = bus.f_step;
            settle_cnt_nx_s = '0;
        end else begin
            case (state_r)
                ST_TUNE: begin
                    if (bus.am_valid) begin
                        if (settle_cnt_r == SETTLE_LAST) begin
                            settle_cnt_nx_s = '0;
                            state_nx_s      = ST_MEASURE;
                        end else begin
                            settle_cnt_nx_s = settle_cnt_r + SET_W'(1);
                        end
                    end else begin
                        settle_cnt_nx_s = settle_cnt_r;
                    end
                end
                ST_MEASURE: begin
                    if (window_done_s) begin
                        state_nx_s = ST_DECIDE;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_DECIDE: begin
                    level_nx_s = avg_s;
                    if (avg_s >= bus.threshold) begin
                        state_nx_s    = ST_LOCK;
`ifdef SCAN_AUTO_RESUME_EN
                        low_seen_nx_s = 1'b0;
`endif
                    end else if (band_end_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        fre_word_nx_s   = next_sum_s[PHASE_WIDTH-1:0];
                        settle_cnt_nx_s = '0;
                        state_nx_s      = ST_TUNE;
                    end
                end
                ST_LOCK: begin
`ifdef SCAN_AUTO_RESUME_EN
                    if (window_done_s) begin
                        level_nx_s = avg_s;
                        if (avg_s < bus.threshold) begin
                            if (low_seen_r) begin
                                low_seen_nx_s = 1'b0;
                                if (band_end_s) begin
                                    state_nx_s = ST_DONE;
                                end else begin
                                    fre_word_nx_s   = next_sum_s[PHASE_WIDTH-1:0];
                                    settle_cnt_nx_s = '0;
                                    state_nx_s      = ST_TUNE;
                                end
                            end else begin
                                low_seen_nx_s = 1'b1;
                            end
                        end else begin
                            low_seen_nx_s = 1'b0;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
`else
                    state_nx_s = state_r;
`endif
                end
                ST_IDLE, ST_DONE: begin
                    state_nx_s = state_r;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, datapath and registered status outputs
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            fre_word_r   <= '0;
            f_stop_r     <= '0;
            f_step_r     <= '0;
            level_r      <= '0;
            settle_cnt_r <= '0;
            busy_r       <= 1'b0;
            locked_r     <= 1'b0;
            done_r       <= 1'b0;
`ifdef SCAN_AUTO_RESUME_EN
            low_seen_r   <= 1'b0;
`endif
        end else begin
            state_r      <= state_nx_s;
            fre_word_r   <= fre_word_nx_s;
            f_stop_r     <= f_stop_nx_s;
            f_step_r     <= f_step_nx_s;
            level_r      <= level_nx_s;
            settle_cnt_r <= settle_cnt_nx_s;
            busy_r       <= (state_nx_s == ST_TUNE) || (state_nx_s == ST_MEASURE) ||
                            (state_nx_s == ST_DECIDE);
            locked_r     <= (state_nx_s == ST_LOCK);
            done_r       <= (state_nx_s == ST_DONE);
`ifdef SCAN_AUTO_RESUME_EN
            low_seen_r   <= low_seen_nx_s;
`endif
        end
    end

    assign bus.Fre_word = fre_word_r;
    assign bus.level    = level_r;
    assign bus.busy     = busy_r;
    assign bus.locked   = locked_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_demod_scan_ctrl.sv
// tb_demod_scan_ctrl
// Self-checking bench for demod_scan_ctrl (SETTLE=3, AVG_LOG2=2).
// Each channel presents a constant magnitude (one optional "hot" channel),
// so the expected outcome of a scan follows directly from the band rules.
module tb_demod_scan_ctrl;

    localparam int PW = 32;
    localparam int OW = 24;

    typedef struct {
        logic [31:0] f_start;
        logic [31:0] f_step;
        logic [31:0] f_stop;
        logic [23:0] thr;
        logic [31:0] hot_f;
        logic [23:0] hot_lvl;
        logic [23:0] base_lvl;
        logic        exp_locked;
        logic        exp_done;
        logic [31:0] exp_fre;
        logic [23:0] exp_level;
    } vec_t;

    logic clk_in;
    logic RST;
    int   checks;
    int   errors;

    demod_scan_ctrl_if #(.PHASE_WIDTH(PW), .OUTPUT_WIDTH(OW)) bus ();

    demod_scan_ctrl #(
        .PHASE_WIDTH  (PW),
        .OUTPUT_WIDTH (OW),
        .SETTLE       (3),
        .AVG_LOG2     (2)
    ) dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive_sample(input logic [23:0] v);
        bus.am_valid = 1'b1;
        bus.am_in    = v;
        tick();
        bus.am_valid = 1'b0;
        tick();
    endtask

    // Expected scan outcome from the band rules, with 64-bit arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        longint f;
        longint n;
        longint l;
        r = v;
        f = longint'(v.f_start);
        r.exp_locked = 1'b0;
        r.exp_done   = 1'b0;
        r.exp_fre    = v.f_start;
        r.exp_level  = 24'd0;
        for (int i = 0; i < 64; i++) begin
            l = (f == longint'(v.hot_f)) ? longint'(v.hot_lvl) : longint'(v.base_lvl);
            r.exp_fre   = f[31:0];
            r.exp_level = l[23:0];
            if (l >= longint'(v.thr)) begin
                r.exp_locked = 1'b1;
                break;
            end
            n = f + longint'(v.f_step);
            if (n > 64'h0000_0000_FFFF_FFFF || n > longint'(v.f_stop) || v.f_step == 32'd0) begin
                r.exp_done = 1'b1;
                break;
            end
            f = n;
        end
        return r;
    endfunction

    task automatic run_scan(input vec_t v, input string tag);
        bus.f_start   = v.f_start;
        bus.f_step    = v.f_step;
        bus.f_stop    = v.f_stop;
        bus.threshold = v.thr;
        bus.am_valid  = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        check({tag, "_start_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_start_fre"}, 64'(bus.Fre_word), 64'(v.f_start));
        for (int c = 0; c < 5000; c++) begin
            if (!bus.busy) break;
            bus.am_valid = ($urandom_range(0, 2) == 0);
            bus.am_in    = (bus.Fre_word == v.hot_f) ? v.hot_lvl : v.base_lvl;
            tick();
        end
        bus.am_valid = 1'b0;
        check({tag, "_timeout"}, 64'(bus.busy), 64'd0);
        check({tag, "_locked"}, 64'(bus.locked), 64'(v.exp_locked));
        check({tag, "_done"}, 64'(bus.done), 64'(v.exp_done));
        check({tag, "_fre"}, 64'(bus.Fre_word), 64'(v.exp_fre));
        check({tag, "_level"}, 64'(bus.level), 64'(v.exp_level));
    endtask

    vec_t vecs [8];
    vec_t rv;
    int   k;
    longint stop_l;

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.f_start = 32'd0; bus.f_stop = 32'd0; bus.f_step = 32'd0;
        bus.threshold = 24'd0; bus.am_valid = 1'b0; bus.am_in = 24'd0;

        // f_start, f_step, f_stop, thr, hot_f, hot_lvl, base_lvl, locked, done, fre, level
        vecs[0] = '{32'd100, 32'd10, 32'd130, 24'd500, 32'd120, 24'd800, 24'd0, 1'b1, 1'b0, 32'd120, 24'd800};
        vecs[1] = '{32'd100, 32'd10, 32'd130, 24'd500, 32'd120, 24'd200, 24'd200, 1'b0, 1'b1, 32'd130, 24'd200};
        vecs[2] = '{32'hFFFF_FFFB, 32'd10, 32'hFFFF_FFFF, 24'd500, 32'd0, 24'd0, 24'd0, 1'b0, 1'b1, 32'hFFFF_FFFB, 24'd0};
        vecs[3] = '{32'd200, 32'd10, 32'd100, 24'd500, 32'd0, 24'd0, 24'd300, 1'b0, 1'b1, 32'd200, 24'd300};
        vecs[4] = '{32'd100, 32'd0, 32'd200, 24'd500, 32'd0, 24'd0, 24'd100, 1'b0, 1'b1, 32'd100, 24'd100};
        vecs[5] = '{32'd100, 32'd10, 32'd130, 24'd500, 32'd110, 24'd500, 24'd499, 1'b1, 1'b0, 32'd110, 24'd500};
        vecs[6] = '{32'd100, 32'd10, 32'd125, 24'd2, 32'd0, 24'd0, 24'd1, 1'b0, 1'b1, 32'd120, 24'd1};
        vecs[7] = '{32'hFFFF_FFF0, 32'd15, 32'hFFFF_FFFF, 24'd8, 32'd0, 24'd0, 24'd7, 1'b0, 1'b1, 32'hFFFF_FFFF, 24'd7};

        tick(); tick();
        RST = 1'b0;
        tick();
        check("rst_fre", 64'(bus.Fre_word), 64'd0);
        check("rst_level", 64'(bus.level), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_locked", 64'(bus.locked), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        // Averaging: samples 3,4,5,6 -> level 4; threshold 4 locks
        bus.f_start = 32'd50; bus.f_step = 32'd10; bus.f_stop = 32'd60;
        bus.threshold = 24'd4;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 3; i++) drive_sample(24'd9);
        drive_sample(24'd3); drive_sample(24'd4); drive_sample(24'd5); drive_sample(24'd6);
        for (int c = 0; c < 20; c++) begin
            if (!bus.busy) break;
            tick();
        end
        check("avg_thr4_locked", 64'(bus.locked), 64'd1);
        check("avg_thr4_level", 64'(bus.level), 64'd4);
        check("avg_thr4_fre", 64'(bus.Fre_word), 64'd50);

        // Same samples, threshold 5 -> steps on to 60
        bus.threshold = 24'd5;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 3; i++) drive_sample(24'd9);
        drive_sample(24'd3); drive_sample(24'd4); drive_sample(24'd5); drive_sample(24'd6);
        for (int c = 0; c < 20; c++) begin
            if (bus.Fre_word == 32'd60) break;
            tick();
        end
        check("avg_thr5_fre", 64'(bus.Fre_word), 64'd60);
        check("avg_thr5_busy", 64'(bus.busy), 64'd1);
        check("avg_thr5_level", 64'(bus.level), 64'd4);

        // Settle at 60, enter MEASURE, start while busy is ignored, then stop
        for (int i = 0; i < 3; i++) drive_sample(24'd9);
        drive_sample(24'd1); drive_sample(24'd1);
        bus.f_start = 32'd777;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("busy_start_fre", 64'(bus.Fre_word), 64'd60);
        check("busy_start_busy", 64'(bus.busy), 64'd1);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("stop_busy", 64'(bus.busy), 64'd0);
        check("stop_fre", 64'(bus.Fre_word), 64'd60);
        check("stop_level", 64'(bus.level), 64'd4);
        check("stop_locked", 64'(bus.locked), 64'd0);
        check("stop_done", 64'(bus.done), 64'd0);

        // start and stop together: stop wins
        bus.f_start = 32'd300;
        bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
        check("startstop_busy", 64'(bus.busy), 64'd0);
        check("startstop_fre", 64'(bus.Fre_word), 64'd60);
        tick();
        check("startstop_idle", 64'(bus.busy), 64'd0);

        // Directed band table
        for (int i = 0; i < 8; i++) begin
            run_scan(vecs[i], $sformatf("vec%0d", i));
        end

        // Randomised bands against the model
        for (int i = 0; i < 40; i++) begin
            rv.f_start = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3000))) : $urandom;
            rv.f_step  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            k = $urandom_range(0, 6);
            stop_l = longint'(rv.f_start) + longint'(rv.f_step) * longint'(k) +
                     longint'($urandom_range(0, 1000));
            if (stop_l > 64'h0000_0000_FFFF_FFFF) stop_l = 64'h0000_0000_FFFF_FFFF;
            rv.f_stop = stop_l[31:0];
            if ($urandom_range(0, 7) == 0 && rv.f_start != 32'd0) rv.f_stop = rv.f_start - 32'd1;
            rv.thr      = 24'($urandom_range(1, 1000));
            rv.base_lvl = 24'($urandom_range(0, 1100));
            rv.hot_f    = rv.f_start + rv.f_step * 32'($urandom_range(0, 7));
            rv.hot_lvl  = 24'($urandom_range(0, 2000));
            rv = model(rv);
            run_scan(rv, $sformatf("rnd%0d", i));
        end

`ifdef SCAN_AUTO_RESUME_EN
        // Lock at 120, then two low windows resume the scan at 130
        run_scan(vecs[0], "auto_lock");
        for (int i = 0; i < 4; i++) drive_sample(24'd0);
        tick();
        check("auto_win1_locked", 64'(bus.locked), 64'd1);
        check("auto_win1_level", 64'(bus.level), 64'd0);
        for (int i = 0; i < 4; i++) drive_sample(24'd0);
        tick();
        check("auto_win2_busy", 64'(bus.busy), 64'd1);
        check("auto_win2_fre", 64'(bus.Fre_word), 64'd130);
        check("auto_win2_locked", 64'(bus.locked), 64'd0);
`endif

        // Reset in the middle of a scan
        bus.f_start = 32'd100; bus.f_step = 32'd10; bus.f_stop = 32'd130;
        bus.threshold = 24'd500;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 5; i++) drive_sample(24'd200);
        RST = 1'b1;
        #1;
        check("midrst_fre", 64'(bus.Fre_word), 64'd0);
        check("midrst_level", 64'(bus.level), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_locked", 64'(bus.locked), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        tick();
        RST = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
